// File: rtl/iddr_align_ctrl_if.sv
// Handshake/data bundle between the IDDR-side source and the
// word-alignment controller.
interface iddr_align_ctrl_if #(
   parameter int WORD_W = 8
);
   localparam int SW = $clog2(WORD_W);

   logic              start;
   logic              d_q1;
   logic              d_q2;
   logic              iddr_ce;
   logic              iddr_rst;
   logic [WORD_W-1:0] word_out;
   logic              word_valid;
   logic              locked;
   logic              fail;
   logic [SW-1:0]     slip;

   modport master (
      output start, d_q1, d_q2,
      input  iddr_ce, iddr_rst, word_out,
      input  word_valid, locked, fail, slip
   );

   modport slave (
      input  start, d_q1, d_q2,
      output iddr_ce, iddr_rst, word_out,
      output word_valid, locked, fail, slip
   );
endinterface

// File: rtl/iddr_align_ctrl.sv
// IDDR word-alignment controller: IDDR reset/flush sequencing,
// Q1/Q2 deserialisation, bit-slip search and aligned word output.
module iddr_align_ctrl #(
   parameter int                WORD_W        = 8,
   parameter logic [WORD_W-1:0] TRAIN_PATTERN = 8'hB9,
   parameter int                RST_CYCLES    = 4,
   parameter int                FLUSH_CYCLES  = 3,
   parameter int                MATCH_COUNT   = 4,
   parameter int                MAX_SWEEPS    = 2
) (
   input  logic             C,
   input  logic             R,
   iddr_align_ctrl_if.slave bus
);
   localparam int HALF = WORD_W / 2;
   localparam int SW   = $clog2(WORD_W);
   localparam int PW   = (HALF > 1) ? $clog2(HALF) : 1;
   localparam int MW   = $clog2(MATCH_COUNT + 1);
   localparam int VW   = $clog2(MAX_SWEEPS + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_RESET, S_FLUSH, S_SEARCH,
      S_VERIFY, S_LOCKED, S_FAIL
   } state_t;

   state_t              r_state;
   logic [2*WORD_W-1:0] r_sr;
   logic [PW-1:0]       r_phase;
   logic [15:0]         r_cnt;
   logic [SW-1:0]       r_slip;
   logic [VW-1:0]       r_sweep;
   logic [MW-1:0]       r_match;
   logic                r_discard;
   logic [WORD_W-1:0]   r_word;
   logic                r_wv;
   logic                r_locked;
   logic                r_fail;
   logic                r_ce;
   logic                r_rst;

   logic              w_restart;
   logic              w_strobe;
   logic [SW:0]       w_base;
   logic [WORD_W-1:0] w_cand;
   logic              w_hit;
   logic              w_wrap;
   logic [SW-1:0]     w_slip_inc;
   logic [VW-1:0]     w_sweep_inc;
   logic              w_adv;

   assign w_restart = bus.start &&
                      (r_state == S_IDLE ||
                       r_state == S_LOCKED ||
                       r_state == S_FAIL);
   assign w_strobe  = r_ce && (r_phase == PW'(HALF - 1));
   assign w_base    = {1'b0, r_slip};
   assign w_cand    = r_sr[w_base +: WORD_W];
   assign w_hit     = (w_cand == TRAIN_PATTERN);
   assign w_wrap    = (r_slip == SW'(WORD_W - 1));
   assign w_slip_inc  = w_wrap ? '0 : r_slip + 1'b1;
   assign w_sweep_inc = r_sweep + 1'b1;
   // A miss in VERIFY, or an undiscarded miss in SEARCH, moves the slip.
   assign w_adv = w_strobe && !w_hit &&
                  ((r_state == S_SEARCH && !r_discard) ||
                   r_state == S_VERIFY);

   // Sequencer, deserialiser and slip search, all outputs registered.
   always_ff @(posedge C) begin
      if (R) begin
         r_state   <= S_IDLE;
         r_sr      <= '0;
         r_phase   <= '0;
         r_cnt     <= '0;
         r_slip    <= '0;
         r_sweep   <= '0;
         r_match   <= '0;
         r_discard <= 1'b0;
         r_word    <= '0;
         r_wv      <= 1'b0;
         r_locked  <= 1'b0;
         r_fail    <= 1'b0;
         r_ce      <= 1'b0;
         r_rst     <= 1'b1;
      end else begin
         r_wv <= 1'b0;
         if (r_ce) begin
            r_sr    <= {r_sr[2*WORD_W-3:0], bus.d_q1, bus.d_q2};
            r_phase <= (r_phase == PW'(HALF - 1)) ? '0
                                                  : r_phase + 1'b1;
         end
         if (w_restart) begin
            r_state   <= S_RESET;
            r_cnt     <= '0;
            r_slip    <= '0;
            r_sweep   <= '0;
            r_match   <= '0;
            r_discard <= 1'b0;
            r_locked  <= 1'b0;
            r_fail    <= 1'b0;
            r_ce      <= 1'b0;
            r_rst     <= 1'b1;
         end else begin
            unique case (r_state)
               S_IDLE: ;
               S_RESET: begin
                  if (r_cnt == 16'(RST_CYCLES - 1)) begin
                     r_state <= S_FLUSH;
                     r_cnt   <= '0;
                     r_rst   <= 1'b0;
                     r_ce    <= 1'b1;
                     r_sr    <= '0;
                     r_phase <= '0;
                  end else begin
                     r_cnt <= r_cnt + 16'd1;
                  end
               end
               S_FLUSH: begin
                  if (r_cnt == 16'(FLUSH_CYCLES - 1))
                     r_state <= S_SEARCH;
                  else
                     r_cnt <= r_cnt + 16'd1;
               end
               S_SEARCH: begin
                  if (w_strobe) begin
                     if (r_discard) begin
                        r_discard <= 1'b0;
                     end else if (w_hit) begin
                        r_match <= MW'(1);
                        if (MATCH_COUNT == 1) begin
                           r_state  <= S_LOCKED;
                           r_locked <= 1'b1;
                        end else begin
                           r_state <= S_VERIFY;
                        end
                     end
                  end
               end
               S_VERIFY: begin
                  if (w_strobe) begin
                     if (w_hit) begin
                        r_match <= r_match + 1'b1;
                        if (r_match == MW'(MATCH_COUNT - 1)) begin
                           r_state  <= S_LOCKED;
                           r_locked <= 1'b1;
                        end
                     end else begin
                        r_state <= S_SEARCH;
                        r_match <= '0;
                     end
                  end
               end
               S_LOCKED: begin
                  if (w_strobe) begin
                     r_word <= w_cand;
                     r_wv   <= 1'b1;
                  end
               end
               S_FAIL: ;
               default: r_state <= S_IDLE;
            endcase
            // Slip step; the strobe after a step is discarded so the
            // window has settled before the next comparison.
            if (w_adv) begin
               r_slip    <= w_slip_inc;
               r_discard <= 1'b1;
               if (w_wrap) begin
                  r_sweep <= w_sweep_inc;
                  if (w_sweep_inc == VW'(MAX_SWEEPS)) begin
                     r_state <= S_FAIL;
                     r_fail  <= 1'b1;
                  end
               end
            end
         end
      end
   end

   assign bus.iddr_ce    = r_ce;
   assign bus.iddr_rst   = r_rst;
   assign bus.word_out   = r_word;
   assign bus.word_valid = r_wv;
   assign bus.locked     = r_locked;
   assign bus.fail       = r_fail;
   assign bus.slip       = r_slip;
endmodule

// File: tb/tb_iddr_align_ctrl.sv
// Randomised bench for iddr_align_ctrl against a strobe-level
// model of the alignment search.
module tb_iddr_align_ctrl;
   localparam int W    = 8;
   localparam int RSTC = 4;
   localparam int FLC  = 3;
   localparam int MC   = 4;
   localparam int MS   = 2;
   localparam int H    = W / 2;
   localparam logic [W-1:0] TP = 8'hB9;
   // Edge (counted from the start edge) of the first SEARCH strobe.
   localparam int FS = RSTC + (FLC / H + 1) * H;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   ecnt = 0;
   int   x0 = 0;
   int   off = 0;
   bit   zero_mode = 1'b0;
   int   cor_lo = -1000;
   logic [W-1:0] cor_msk = '0;
   bit   allow_valid = 1'b0;
   int   exp_sv = 0;
   int   vcount = 0;
   int   nvec = 0;
   int   nerr = 0;

   iddr_align_ctrl_if #(.WORD_W(W)) bus ();

   iddr_align_ctrl #(
      .WORD_W(W), .TRAIN_PATTERN(TP), .RST_CYCLES(RSTC),
      .FLUSH_CYCLES(FLC), .MATCH_COUNT(MC), .MAX_SWEEPS(MS)
   ) dut (
      .C(clk),
      .R(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) ecnt <= ecnt + 1;

   task automatic chk(input string tag,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   function automatic int modw(input int a);
      return ((a % W) + W) % W;
   endfunction

   // Serial stream: TP repeated, its MSB at bit positions = off mod W.
   function automatic bit stream_bit(input int n);
      logic [W-1:0] p;
      logic [W-1:0] m;
      int idx;
      bit b;
      p = TP;
      m = cor_msk;
      if (zero_mode) return 1'b0;
      idx = modw(n - off);
      b = p[W-1-idx];
      if (n >= cor_lo && n < cor_lo + W) b = b ^ m[W-1-idx];
      return b;
   endfunction

   // Pair sampled at edge k after start holds positions 2k, 2k+1.
   always @(negedge clk) begin
      int k;
      k = ecnt + 1 - x0;
      bus.d_q1 = stream_bit(2 * k);
      bus.d_q2 = stream_bit(2 * k + 1);
   end

   always @(negedge clk) begin
      if (!rst && bus.word_valid) begin
         vcount++;
         chk("wv_allowed", 32'(allow_valid), 1);
         chk("word_out", bus.word_out, TP);
         chk("wv_slip", bus.slip, exp_sv);
         chk("wv_locked", bus.locked, 1);
      end
   end

   function automatic int se(input int q);
      return FS + q * H;
   endfunction

   // Window at offset s reads the aligned word when s == 2*RST - off.
   function automatic int exp_slip(input int o);
      return modw(2 * RSTC - o);
   endfunction

   // Slip j is tried on strobe 2j of each sweep; the very first
   // strobe sees a partly filled register, so slip 0 hits a sweep late.
   function automatic int lock_q(input int s);
      int a;
      a = (s == 0) ? W : s;
      return 2 * a + MC - 1;
   endfunction

   task automatic wait_edge(input int k);
      while ((ecnt - x0) < k) @(negedge clk);
   endtask

   task automatic pulse_start(input int o, input bit z,
                              input bit av, input int sv);
      @(negedge clk);
      off = o;
      zero_mode = z;
      cor_lo = -1000;
      cor_msk = '0;
      x0 = ecnt + 1;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      allow_valid = av;
      exp_sv = sv;
      chk("st_locked", bus.locked, 0);
      chk("st_fail", bus.fail, 0);
      chk("st_rst", bus.iddr_rst, 1);
      wait_edge(RSTC - 1);
      chk("rst_hold_ce", bus.iddr_ce, 0);
      chk("rst_hold_rst", bus.iddr_rst, 1);
      wait_edge(RSTC);
      chk("ce_rise", bus.iddr_ce, 1);
      chk("rst_fall", bus.iddr_rst, 0);
   endtask

   task automatic run_lock(input int o);
      int s;
      int ql;
      s = exp_slip(o);
      ql = lock_q(s);
      pulse_start(o, 1'b0, 1'b1, s);
      wait_edge(se(ql) - 1);
      chk("pre_lock", bus.locked, 0);
      wait_edge(se(ql));
      chk("lock", bus.locked, 1);
      chk("lock_slip", bus.slip, s);
      chk("lock_fail", bus.fail, 0);
      vcount = 0;
      wait_edge(se(ql) + 10 * H + 1);
      chk("n_valid", vcount, 10);
   endtask

   task automatic chk_reset(input string t);
      chk({t, "_rst"}, bus.iddr_rst, 1);
      chk({t, "_ce"}, bus.iddr_ce, 0);
      chk({t, "_locked"}, bus.locked, 0);
      chk({t, "_fail"}, bus.fail, 0);
      chk({t, "_slip"}, bus.slip, 0);
      chk({t, "_wv"}, bus.word_valid, 0);
   endtask

   initial begin
      int ord[W-1];
      int s, o, qc, ec, ql, qf, r, j, t;
      bus.start = 1'b1;
      bus.d_q1 = 1'b0;
      bus.d_q2 = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk_reset("por");
      chk("por_word", bus.word_out, 0);
      bus.start = 1'b0;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("idle_ce", bus.iddr_ce, 0);
      chk("idle_rst", bus.iddr_rst, 1);

      run_lock(0);

      for (int i = 0; i < W - 1; i++) ord[i] = i + 1;
      for (int i = W - 2; i > 0; i--) begin
         j = $urandom_range(0, i);
         t = ord[i];
         ord[i] = ord[j];
         ord[j] = t;
      end
      for (int i = 0; i < W - 1; i++) run_lock(ord[i]);

      pulse_start(0, 1'b1, 1'b0, 0);
      qf = 2 * (W * MS - 1);
      wait_edge(se(qf) - 1);
      chk("pre_fail", bus.fail, 0);
      wait_edge(se(qf));
      chk("fail", bus.fail, 1);
      chk("fail_slip", bus.slip, 0);
      chk("fail_locked", bus.locked, 0);
      chk("fail_ce", bus.iddr_ce, 1);
      wait_edge(se(qf) + 20);
      chk("fail_sticky", bus.fail, 1);

      s = $urandom_range(1, W - 1);
      o = modw(2 * RSTC - s);
      pulse_start(o, 1'b0, 1'b1, s);
      qc = 2 * s + 2;
      ec = se(qc);
      cor_msk = W'($urandom_range(1, (1 << W) - 1));
      cor_lo = 2 * ec - s - W;
      wait_edge(se(2 * s + 1));
      chk("vfy_locked", bus.locked, 0);
      chk("vfy_slip", bus.slip, s);
      wait_edge(ec);
      chk("brk_slip", bus.slip, modw(s + 1));
      chk("brk_locked", bus.locked, 0);
      ql = qc + 2 * W + MC - 1;
      wait_edge(se(ql) - 1);
      chk("relock_pre", bus.locked, 0);
      wait_edge(se(ql));
      chk("relock", bus.locked, 1);
      chk("relock_slip", bus.slip, s);
      wait_edge(se(ql) + 20);

      s = $urandom_range(1, W - 1);
      o = modw(2 * RSTC - s);
      pulse_start(o, 1'b0, 1'b1, s);
      r = se(2 * s) + $urandom_range(1, 3 * H - 1);
      wait_edge(r - 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk_reset("mid");

      run_lock($urandom_range(0, W - 1));
      run_lock($urandom_range(0, W - 1));

      $display("== %0d vectors applied, %0d miscompares ==",
               nvec, nerr);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/iddr_align_ctrl.md
Name: iddr_align_ctrl

Overview:
Word-alignment controller that sequences one IDDR input channel (SAME_EDGE_PIPELINED mode) and deserialises its output.
- Holds the IDDR in reset, then enables it and flushes its pipeline.
- Gathers Q1/Q2 bit pairs into WORD_W-bit words and sweeps a bit-slip offset until a training word is seen MATCH_COUNT times in a row.
- Then streams aligned words to downstream logic.
- Sits between the IDDR primitive and the link/protocol layer.

Parameters:
- WORD_W, 8, deserialised word width; even, 4..16.
- TRAIN_PATTERN, 8'hB9, WORD_W-bit training word; must not be rotation-symmetric.
- RST_CYCLES, 4, cycles iddr_rst is held in RESET_IDDR (≥1).
- FLUSH_CYCLES, 3, cycles after IDDR enable before words are evaluated (≥2, covers IDDR pipeline).
- MATCH_COUNT, 4, consecutive matching words required to lock (≥1).
- MAX_SWEEPS, 2, full slip sweeps (WORD_W offsets each) before declaring failure (≥1).

Ports:
- C  in  1  clock, same clock as the IDDR C input.
- R  in  1  reset, synchronous, active-high; resets every register of this block.
- start  in  1  pulse; begins alignment from IDLE, or restarts from LOCKED/FAIL.
- d_q1  in  1  IDDR Q1, the earlier bit of each pair.
- d_q2  in  1  IDDR Q2, the later bit of each pair.
- iddr_ce  out  1  drives IDDR CE.
- iddr_rst  out  1  drives IDDR R.
- word_out  out  WORD_W  aligned word, MSB = earliest bit.
- word_valid  out  1  one-cycle strobe; word_out is valid while it is high.
- locked  out  1  alignment achieved.
- fail  out  1  alignment failed; sticky until start or R.
- slip  out  clog2(WORD_W)  current bit-slip offset.

Behaviour:
- Every output is registered. Reset values: state=IDLE, iddr_rst=1, iddr_ce=0, word_out=0, word_valid=0, locked=0, fail=0, slip=0, sweep=0, match=0.
- Reset and start: R has priority over everything, including a simultaneous start. R asserted mid-operation returns the block to the reset values on the next edge.
- IDDR control: iddr_rst=1 only in IDLE and RESET_IDDR. iddr_ce=1 in every state except IDLE and RESET_IDDR.
- Shift register: sr is 2*WORD_W bits. Every cycle with iddr_ce=1, sr <= {sr[2W-3:0], d_q1, d_q2}.
- Phase counter: counts 0..WORD_W/2-1 and wraps. A strobe occurs in the cycle where phase==WORD_W/2-1. sr and phase are cleared on FLUSH entry.
- Candidate word: cand = sr[slip+WORD_W-1 : slip]. It is combinational in slip, evaluated only on strobes.
- FSM states:
  - IDLE: start -> RESET_IDDR. Other inputs are ignored.
  - RESET_IDDR: lasts exactly RST_CYCLES cycles, then -> FLUSH. slip, sweep and match are cleared on entry.
  - FLUSH: iddr_ce=1 for FLUSH_CYCLES cycles. Strobes in this state are ignored. Then -> SEARCH.
  - SEARCH, on each non-discarded strobe:
    - cand==TRAIN_PATTERN -> VERIFY with match=1.
    - otherwise advance slip: slip+1 mod WORD_W, then discard the next strobe (settle).
  - Slip wrap: when slip wraps WORD_W-1 -> 0, sweep increments. When sweep reaches MAX_SWEEPS -> FAIL, with slip left at 0.
  - VERIFY, on each strobe:
    - match -> match+1; reaching MATCH_COUNT -> LOCKED.
    - mismatch -> back to SEARCH, with the same slip-advance/discard/wrap rules as above.
  - LOCKED: locked=1 and slip is frozen. On each strobe, word_out<=cand and word_valid=1 the following cycle. start -> RESET_IDDR with locked=0 the next cycle. No data monitoring.
  - FAIL: fail=1, iddr_ce=1, no word_valid. start -> RESET_IDDR with fail cleared.
- word_valid is never asserted outside LOCKED. word_out holds its last value outside LOCKED.
- Worst-case lock time: (2*WORD_W*MAX_SWEEPS + MATCH_COUNT) strobes after FLUSH.

Test Plan:
- Reset values: R=1 for 3 cycles -> iddr_rst=1, iddr_ce=0, locked=0, fail=0, slip=0, word_valid=0. start with R=1 -> no state change.
- Aligned lock: repeat 8'hB9 serially at bit offset 0, then pulse start -> locked rises within 2*8*2+4 strobes. Every subsequent word_valid shows word_out==8'hB9 with slip constant.
- Skewed lock: the same stream shifted by 1..7 bits (sweep all seven) -> each case locks, word_out==8'hB9, and slip differs per offset. Sequence: RESET_IDDR holds iddr_rst for exactly 4 cycles, then iddr_ce rises.
- Failure: constant 8'h00 stream -> fail=1 after 16 slip advances, locked=0, no word_valid. Then start -> fail=0 next cycle and iddr_rst=1.
- Verify break: 2 correct words, then one corrupted word, then the correct stream -> return to SEARCH, slip advances by 1, eventually locks again with word_out==8'hB9.
- Mid-operation: R during VERIFY -> next edge gives reset values. start in LOCKED -> locked=0 next cycle, iddr_rst=1 for 4 cycles, then relock.
